ld_st_control_unit: RTL

- Synthesisable Moore control sequencer that drives the mini-CPU data_path through instruction fetch and the ld, ldi and st execute sequences (T0..T7).
- Generalises the hand-sequenced load/store timing into hardware.
- Adds parametrised memory wait states with a ready handshake, a timeout fault, illegal-opcode trapping and run/idle control.
- Sits beside data_path; its outputs connect directly to the data_path control inputs.

---
 rtl/ld_st_control_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ld_st_control_unit.sv
// ld_st_control_unit: Moore fetch/ld/ldi/st sequencer driving data_path, with memory wait states, timeout and illegal-opcode faults.
// Optional retired-instruction and stall counters are enabled by defining LDST_PERF_EN.
module ld_st_control_unit #(
  parameter int              OPC_W       = 5,
  parameter logic [OPC_W-1:0] OPC_LD      = OPC_W'(0),
  parameter logic [OPC_W-1:0] OPC_LDI     = OPC_W'(1),
  parameter logic [OPC_W-1:0] OPC_ST      = OPC_W'(2),
  parameter logic [4:0]      ALU_ADD_OP  = 5'b00011,
  parameter int              MEM_TIMEOUT = 16
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        PCin,
  output logic        Zlowout,
  output logic        ZHighin,
  output logic        Zlowin,
  output logic        Read,
  output logic        Write,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Gra,
  output logic        Grb,
  output logic        BAOut,
  output logic        Yin,
  output logic        Cout,
  output logic        Rin,
  output logic        Rout,
  output logic [4:0]  op,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] instr_count,
  output logic [31:0] stall_count
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] T0     = 4'd1;
  localparam logic [3:0] T1     = 4'd2;
  localparam logic [3:0] T2     = 4'd3;
  localparam logic [3:0] T3     = 4'd4;
  localparam logic [3:0] T4     = 4'd5;
  localparam logic [3:0] T5     = 4'd6;
  localparam logic [3:0] T6     = 4'd7;
  localparam logic [3:0] T7     = 4'd8;
  localparam logic [3:0] RETIRE = 4'd9;
  localparam logic [3:0] FAULT  = 4'd10;

  logic [3:0]       state, nxt;
  logic [CW-1:0]    cnt;
  logic [OPC_W-1:0] opc;
  logic [31-OPC_W:0] unused_ir;
  logic             is_ld, is_ldi, is_st, legal, wst, tmo;

  assign opc       = ir[31 -: OPC_W];
  assign unused_ir = ir[31-OPC_W:0];
  assign is_ld     = opc == OPC_LD;
  assign is_ldi    = opc == OPC_LDI;
  assign is_st     = opc == OPC_ST;
  assign legal     = is_ld | is_ldi | is_st;
  assign wst       = (state == T1) | (state == T6 & is_ld) | (state == T7 & is_st);
  // the cycle that would bring the count to MEM_TIMEOUT without ready is the last one allowed
  assign tmo       = cnt == CW'(MEM_TIMEOUT - 1);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = run ? T0 : IDLE;
      T0:      nxt = T1;
      T1:      nxt = mem_ready ? T2 : tmo ? FAULT : T1;
      T2:      nxt = T3;
      T3:      nxt = legal ? T4 : FAULT;
      T4:      nxt = T5;
      T5:      nxt = is_ldi ? RETIRE : T6;
      T6:      nxt = !is_ld ? T7 : mem_ready ? T7 : tmo ? FAULT : T6;
      T7:      nxt = !is_st ? RETIRE : mem_ready ? RETIRE : tmo ? FAULT : T7;
      RETIRE:  nxt = run ? T0 : IDLE;
      default: nxt = FAULT;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (clear) begin
      state      <= IDLE;
      cnt        <= '0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end else begin
      state <= nxt;
      cnt   <= (wst && !mem_ready && nxt == state) ? cnt + 1'b1 : '0;
      if (nxt == FAULT && state != FAULT) begin
        fault      <= 1'b1;
        fault_code <= (state == T3) ? 2'b01 : 2'b10;
      end
    end
  end

  assign PCout   = state == T0;
  assign MARin   = (state == T0) | (state == T5 & !is_ldi);
  assign IncPC   = state == T0;
  assign PCin    = state == T1 && cnt == '0;
  assign Zlowout = (state == T1) | (state == T5);
  assign ZHighin = (state == T0) | (state == T4);
  assign Zlowin  = (state == T0) | (state == T4);
  assign Read    = (state == T1) | (state == T6 & is_ld);
  assign Write   = state == T7 & is_st;
  assign MDRin   = (state == T1) | (state == T6);
  assign MDRout  = (state == T2) | (state == T7 & is_ld);
  assign IRin    = state == T2;
  assign Gra     = (state == T5 & is_ldi) | (state == T6 & is_st) | (state == T7 & is_ld);
  assign Grb     = state == T3 & legal;
  assign BAOut   = state == T3 & legal;
  assign Yin     = state == T3 & legal;
  assign Cout    = state == T4;
  assign Rin     = (state == T5 & is_ldi) | (state == T7 & is_ld);
  assign Rout    = state == T6 & is_st;
  assign op      = (state == T4) ? ALU_ADD_OP : 5'd0;
  assign busy    = state != IDLE && state != FAULT;

`ifdef LDST_PERF_EN
  always_ff @(posedge Clock) begin
    if (clear) begin
      instr_count <= '0;
      stall_count <= '0;
    end else begin
      instr_count <= instr_count + 32'(state == RETIRE);
      stall_count <= stall_count + 32'(wst && !mem_ready);
    end
  end
`else
  assign instr_count = '0;
  assign stall_count = '0;
`endif
endmodule
